alu_seq: RTL and testbench

//  Clocked, parametrised successor of the combinational datapath ALU: WIDTH-bit operands,

---
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_seq.sv | 146 ++++++++++++++
 tb/tb_alu_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake and data bundle for alu_seq: request side (operands/operation)
// and response side (registered result and flags).
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [5:0]       aluOperation;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             cy;
  logic             ov;
  logic             out_valid;
  logic             out_ready;

  // Producer of operations / consumer of results
  modport master (
    output in_valid, mode, aluOperation, x, y, out_ready,
    input  in_ready, out, zr, ng, cy, ov, out_valid
  );

  // The ALU itself
  modport slave (
    input  in_valid, mode, aluOperation, x, y, out_ready,
    output in_ready, out, zr, ng, cy, ov, out_valid
  );
endinterface

// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle zx/nx/zy/ny/f/no logic/add operation or an
// iterative shift-add multiply (one bit of y per cycle, LSB first), with a
// registered result, carry/overflow flags and valid/ready handshakes.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state_q, state_d;

  logic                 accept;
  logic                 last_step;
  logic                 ld_alu;
  logic                 ld_mul;

  // ALU datapath
  logic [WIDTH-1:0]     x1, x2, y1, y2;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     s;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_cy;
  logic                 alu_ov;

  // Multiplier state
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_step;
  logic [CNT_W-1:0]     cnt_q;

  // Result registers
  logic [WIDTH-1:0]     res_d;
  logic                 cy_d;
  logic                 ov_d;
  logic [WIDTH-1:0]     out_q;
  logic                 zr_q;
  logic                 ng_q;
  logic                 cy_q;
  logic                 ov_q;

  // Ready is masked while reset is held so nothing appears acceptable then
  assign bus.in_ready  = rst_n & (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.cy        = cy_q;
  assign bus.ov        = ov_q;

  assign accept    = bus.in_valid & bus.in_ready;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign ld_alu    = (state_q == IDLE) & accept & ~bus.mode;
  assign ld_mul    = (state_q == MUL) & last_step;

  // Single-cycle ALU operation; carry/overflow are taken before output negation
  always_comb begin
    x1      = bus.aluOperation[5] ? '0 : bus.x;
    x2      = bus.aluOperation[4] ? ~x1 : x1;
    y1      = bus.aluOperation[3] ? '0 : bus.y;
    y2      = bus.aluOperation[2] ? ~y1 : y1;
    sum     = {1'b0, x2} + {1'b0, y2};
    s       = bus.aluOperation[1] ? sum[WIDTH-1:0] : (x2 & y2);
    alu_res = bus.aluOperation[0] ? ~s : s;
    alu_cy  = bus.aluOperation[1] & sum[WIDTH];
    alu_ov  = bus.aluOperation[1] & (x2[WIDTH-1] == y2[WIDTH-1])
                                  & (s[WIDTH-1] != x2[WIDTH-1]);
  end

  // One shift-add step: add the shifted multiplicand when the current y bit is set
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Select what gets loaded into the result registers
  always_comb begin
    res_d = alu_res;
    cy_d  = alu_cy;
    ov_d  = alu_ov;
    if (state_q == MUL) begin
      res_d = acc_step[WIDTH-1:0];
      cy_d  = 1'b0;
      ov_d  = |acc_step[2*WIDTH-1:WIDTH];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)        state_d = bus.mode ? MUL : DONE;
      MUL:  if (last_step)     state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Multiplier operands, accumulator and step counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if ((state_q == IDLE) && accept && bus.mode) begin
      mcand_q  <= {{WIDTH{1'b0}}, bus.x};
      mplier_q <= bus.y;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == MUL) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_step;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  // Result and flag registers; held between loads, including through DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      zr_q  <= 1'b0;
      ng_q  <= 1'b0;
      cy_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else if (ld_alu || ld_mul) begin
      out_q <= res_d;
      zr_q  <= (res_d == '0);
      ng_q  <= res_d[WIDTH-1];
      cy_q  <= cy_d;
      ov_q  <= ov_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {out, zr, ng, cy, ov} from plain integer arithmetic
  function automatic logic [W+3:0] model(input logic m, input logic [5:0] op,
                                         input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned ua, ub, us;
    longint          sa, sb, ss;
    logic [W-1:0]    a1, b1, r;
    logic            c, v;
    c = 1'b0;
    v = 1'b0;
    if (m) begin
      ua = 64'(a);
      ub = 64'(b);
      us = ua * ub;
      r  = us[W-1:0];
      v  = (us >> W) != 0;
    end else begin
      a1 = op[5] ? '0 : a;
      if (op[4]) a1 = ~a1;
      b1 = op[3] ? '0 : b;
      if (op[2]) b1 = ~b1;
      if (op[1]) begin
        ua = 64'(a1);
        ub = 64'(b1);
        us = ua + ub;
        r  = us[W-1:0];
        c  = us >= (64'd1 << W);
        sa = longint'($signed(a1));
        sb = longint'($signed(b1));
        ss = sa + sb;
        v  = (ss > ((64'sd1 <<< (W-1)) - 1)) || (ss < -(64'sd1 <<< (W-1)));
      end else begin
        r = a1 & b1;
      end
      if (op[0]) r = ~r;
    end
    return {r, (r == '0), r[W-1], c, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+3:0] outs();
    return {bus.out, bus.zr, bus.ng, bus.cy, bus.ov};
  endfunction

  // Issue one operation, wait for its result, optionally stall, then consume it
  task automatic do_op(input string tag, input logic m, input logic [5:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    int           n;
    logic         busy_ok;
    logic [W+3:0] e;
    e = model(m, op, a, b);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.mode = m;
    bus.aluOperation = op;
    bus.x = a;
    bus.y = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.x = $urandom;
    bus.y = $urandom;
    bus.mode = 1'($urandom);
    bus.aluOperation = 6'($urandom);
    busy_ok = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, 64'(n), m ? 64'(W) : 64'd0);
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_result"}, 64'(outs()), 64'(e));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.x = $urandom;
      bus.y = $urandom;
      @(posedge clk); #1;
      chk({tag, "_hold"}, 64'({bus.out_valid, bus.in_ready, outs()}), 64'({2'b10, e}));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_release"}, 64'({bus.out_valid, bus.in_ready, outs()}), 64'({2'b01, e}));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.mode = 1'b0;
    bus.aluOperation = '0;
    bus.x = '0;
    bus.y = '0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 64'({bus.out_valid, outs()}), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", 64'(bus.in_ready), 64'd1);

    // Directed cases
    do_op("t1_add", 1'b0, 6'b000010, 32'h0001F800, 32'h0001F800, 0);
    do_op("t2_sub", 1'b0, 6'b010011, 32'd5, 32'd7, 0);
    do_op("t2_zero", 1'b0, 6'b101010, 32'h1234, 32'h5678, 0);
    do_op("t3_ov", 1'b0, 6'b000010, 32'h7FFFFFFF, 32'd1, 0);
    do_op("t3_cy", 1'b0, 6'b000010, 32'hFFFFFFFF, 32'd1, 0);
    do_op("t4_mul", 1'b1, 6'b000000, 32'd1234, 32'd5678, 0);
    chk("t4_mul_value", 64'(bus.out), 64'd7006652);
    do_op("t4_mul_ov", 1'b1, 6'b000000, 32'h00010000, 32'h00010000, 0);
    do_op("t5_backpressure", 1'b0, 6'b000010, 32'h00000123, 32'h00000456, 10);

    // Reset in the middle of a multiply
    bus.in_valid = 1'b1;
    bus.mode = 1'b1;
    bus.x = 32'd99999;
    bus.y = 32'd77777;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outs", 64'({bus.out_valid, outs()}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("t6_ready", 64'(bus.in_ready), 64'd1);
    do_op("t6_add", 1'b0, 6'b000010, 32'd3, 32'd4, 0);
    chk("t6_value", 64'(bus.out), 64'd7);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      do_op($sformatf("rand%0d", i), ($urandom_range(0, 3) == 0), 6'($urandom),
            $urandom, $urandom, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
